// File: rtl/ram_frame_pkg.sv
// Shared types and constants for the RAM frame sequencer.
package ram_frame_pkg;

    localparam int unsigned LEN_W    = 9;
    localparam int unsigned ADDR_LSB = 16;
    localparam int unsigned DATA_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD,
        RD_REQ,
        RD_WAIT,
        RD_OUT
    } state_e;

    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                   input logic [LEN_W-1:0] depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/ram_frame_ctrl.sv
// Frame sequencer: clears the RAM, loads one frame of upstream bytes as
// address-tagged write beats, then reads it back in order to the consumer.
module ram_frame_ctrl
    import ram_frame_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [7:0]       s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [31:0]      ram_s_tdata,
    output logic             ram_s_tvalid,
    input  logic             ram_s_tready,
    input  logic [31:0]      ram_m_tdata,
    input  logic             ram_m_tvalid,
    output logic             ram_m_tready,
    output logic             ram_clr_n,
    output logic [7:0]       m_axis_tdata,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast
);

    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [LEN_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             mvalid_q, mvalid_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [31:0]      beat;

    // Only the data byte of a read word is meaningful.
    logic unused_rd_bits;
    assign unused_rd_bits = ^ram_m_tdata[31:8];

    always_comb begin
        beat                    = '0;
        beat[ADDR_LSB +: 8]     = wr_cnt_q[7:0];
        beat[DATA_LSB +: 8]     = s_axis_tdata;
    end

    always_comb begin
        state_d       = state_q;
        len_d         = len_q;
        wr_cnt_d      = wr_cnt_q;
        rd_cnt_d      = rd_cnt_q;
        data_d        = data_q;
        mvalid_d      = mvalid_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        s_axis_tready = 1'b0;
        ram_s_tvalid  = 1'b0;
        ram_s_tdata   = '0;
        ram_m_tready  = 1'b0;
        ram_clr_n     = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        len_d    = clamp_len(len, DEPTH_L);
                        wr_cnt_d = '0;
                        rd_cnt_d = '0;
                        state_d  = CLEAR;
                    end
                end
            end
            CLEAR: begin
                ram_clr_n = 1'b0;
                state_d   = LOAD;
            end
            LOAD: begin
                if (wr_cnt_q < len_q) begin
                    s_axis_tready = ram_s_tready;
                    ram_s_tvalid  = s_axis_tvalid;
                    ram_s_tdata   = beat;
                    if (s_axis_tvalid && ram_s_tready) begin
                        wr_cnt_d = wr_cnt_q + ONE;
                    end
                end
                if (wr_cnt_d == len_q) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                ram_m_tready = 1'b1;
                state_d      = RD_WAIT;
            end
            RD_WAIT: begin
                if (ram_m_tvalid) begin
                    data_d   = ram_m_tdata[7:0];
                    mvalid_d = 1'b1;
                    state_d  = RD_OUT;
                end
            end
            RD_OUT: begin
                if (m_axis_tready) begin
                    mvalid_d = 1'b0;
                    if (rd_cnt_q < len_q) begin
                        rd_cnt_d = rd_cnt_q + ONE;
                    end
                    if (rd_cnt_q + ONE < len_q) begin
                        state_d = RD_REQ;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            len_q    <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            data_q   <= '0;
            mvalid_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            data_q   <= data_d;
            mvalid_q <= mvalid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = mvalid_q;
    assign m_axis_tlast  = mvalid_q && (rd_cnt_q == len_q - ONE);

endmodule
